// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction game controller.
package reaction_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        GO     = 2'd2,
        RESULT = 2'd3
    } state_t;

    localparam logic [1:0]  MODE_EASY  = 2'b00;
    localparam logic [1:0]  MODE_REG   = 2'b01;
    localparam logic [1:0]  MODE_HARD  = 2'b10;

    localparam logic [13:0] SCORE_MISS = 14'd9999;
    localparam logic [13:0] LIM_EASY   = 14'd9999;
    localparam logic [13:0] LIM_REG    = 14'd1000;
    localparam logic [13:0] LIM_HARD   = 14'd500;

    localparam logic [15:0] LFSR_SEED  = 16'hACE1;

    // The unused switch code 11 is treated as regular mode.
    function automatic logic [1:0] coerce_mode(input logic [1:0] sw);
        return (sw == 2'b11) ? MODE_REG : sw;
    endfunction

    function automatic logic [13:0] mode_limit(input logic [1:0] m);
        case (m)
            MODE_EASY: return LIM_EASY;
            MODE_HARD: return LIM_HARD;
            default:   return LIM_REG;
        endcase
    endfunction

endpackage

// File: rtl/reaction_ctrl_btn_sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// Emits a one-cycle pulse three cycles after the button input rises.
module btn_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    logic       meta_reg;
    logic       sync_reg;
    logic       prev_reg;
    logic       pulse_reg;
    logic [1:0] warm_reg;

    // warm_reg masks the false low-to-high the reset zeros would otherwise
    // show when a button is held through reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_reg  <= 1'b0;
            sync_reg  <= 1'b0;
            prev_reg  <= 1'b0;
            pulse_reg <= 1'b0;
            warm_reg  <= 2'd0;
        end else begin
            meta_reg  <= btn;
            sync_reg  <= meta_reg;
            prev_reg  <= sync_reg;
            pulse_reg <= sync_reg & ~prev_reg & (warm_reg == 2'd3);
            if (warm_reg != 2'd3)
                warm_reg <= warm_reg + 2'd1;
        end
    end

    assign pulse = pulse_reg;

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction game controller: button conditioning, random arm delay,
// millisecond reaction timing and display state for the 7-segment driver.
module reaction_ctrl
    import reaction_pkg::*;
#(
    parameter int TICKS_PER_MS  = 100000,
    parameter int DELAY_BASE_MS = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_start,
    input  logic        btn_react,
    input  logic [1:0]  sw_mode,
    output logic [13:0] number,
    output logic [1:0]  select,
    output logic [1:0]  mode,
    output logic        led_go
);

    localparam int CNT_W   = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam int DELAY_W = $clog2(DELAY_BASE_MS + 2048);
    localparam logic [CNT_W-1:0]   TICK_LAST  = CNT_W'(TICKS_PER_MS - 1);
    localparam logic [DELAY_W-1:0] DELAY_BASE = DELAY_W'(DELAY_BASE_MS);

    logic               start_p;
    logic               react_p;
    logic [15:0]        lfsr_reg;
    logic [CNT_W-1:0]   tick_cnt_reg;
    logic               tick;
    state_t             state_reg, state_next;
    logic [13:0]        number_reg, number_next;
    logic [1:0]         mode_reg, mode_next;
    logic [DELAY_W-1:0] delay_reg, delay_next;
    logic [13:0]        limit;

    btn_sync_edge u_start (.clk(clk), .rst(rst), .btn(btn_start), .pulse(start_p));
    btn_sync_edge u_react (.clk(clk), .rst(rst), .btn(btn_react), .pulse(react_p));

    // Fibonacci LFSR, taps 16,14,13,11; free-running so the delay depends on press timing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            lfsr_reg <= LFSR_SEED;
        else
            lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
    end

    assign tick = (tick_cnt_reg == TICK_LAST);

    // Restarting on every state change makes the first ms after entry full length.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            tick_cnt_reg <= '0;
        else if (state_next != state_reg || tick)
            tick_cnt_reg <= '0;
        else
            tick_cnt_reg <= tick_cnt_reg + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    assign limit = mode_limit(mode_reg);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:   if (start_p) state_next = WAIT;
            WAIT: begin
                if (react_p)
                    state_next = RESULT;
                else if (tick && delay_reg <= DELAY_W'(1))
                    state_next = GO;
            end
            GO:     if (react_p || number_reg >= limit) state_next = RESULT;
            RESULT: if (start_p) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        select = 2'd0;
        led_go = 1'b0;
        case (state_reg)
            IDLE:    select = 2'd0;
            WAIT:    select = 2'd1;
            GO: begin
                select = 2'd2;
                led_go = 1'b1;
            end
            RESULT:  select = 2'd3;
            default: select = 2'd0;
        endcase
    end

    always_comb begin
        number_next = number_reg;
        mode_next   = mode_reg;
        delay_next  = delay_reg;
        case (state_reg)
            IDLE: begin
                number_next = '0;
                if (start_p)
                    delay_next = DELAY_BASE + DELAY_W'(lfsr_reg[10:0]);
                else
                    mode_next = coerce_mode(sw_mode);
            end
            WAIT: begin
                number_next = '0;
                if (react_p)
                    number_next = SCORE_MISS;
                else if (tick)
                    delay_next = delay_reg - DELAY_W'(1);
            end
            GO: begin
                // A react in the same cycle as a tick captures the pre-tick count.
                if (!react_p) begin
                    if (number_reg >= limit)
                        number_next = SCORE_MISS;
                    else if (tick && number_reg != SCORE_MISS)
                        number_next = number_reg + 14'd1;
                end
            end
            RESULT: if (start_p) number_next = '0;
            default: number_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            number_reg <= '0;
            mode_reg   <= MODE_EASY;
            delay_reg  <= '0;
        end else begin
            number_reg <= number_next;
            mode_reg   <= mode_next;
            delay_reg  <= delay_next;
        end
    end

    assign number = number_reg;
    assign mode   = mode_reg;

endmodule

// File: tb/tb_reaction_ctrl.sv
// Randomized self-checking bench for reaction_ctrl against a behavioural
// game model (ms arithmetic plus a reference LFSR).
module tb_reaction_ctrl;

    localparam int T    = 4;
    localparam int BASE = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        btn_start = 1'b0;
    logic        btn_react = 1'b0;
    logic [1:0]  sw_mode = 2'b00;
    logic [13:0] number;
    logic [1:0]  select;
    logic [1:0]  mode;
    logic        led_go;

    reaction_ctrl #(.TICKS_PER_MS(T), .DELAY_BASE_MS(BASE)) dut (
        .clk(clk), .rst(rst), .btn_start(btn_start), .btn_react(btn_react),
        .sw_mode(sw_mode), .number(number), .select(select), .mode(mode), .led_go(led_go)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic int exp_mode(input logic [1:0] sw);
        return (sw == 2'b11) ? 1 : int'(sw);
    endfunction

    // Reference LFSR; ref_prev is the value the design sampled at the last edge.
    logic [15:0] ref_lfsr, ref_prev;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ref_lfsr <= 16'hACE1;
            ref_prev <= 16'hACE1;
        end else begin
            ref_prev <= ref_lfsr;
            ref_lfsr <= lfsr_step(ref_lfsr);
        end
    end

    // Event timestamps, in falling-edge counts.
    int          cyc_n = 0;
    int          t_wait = 0, t_go = 0, t_result = 0;
    int          exp_delay = 0, num_before_result = 0;
    logic [1:0]  prev_sel = 2'd0;
    logic        prev_go = 1'b0;
    logic [13:0] prev_num = '0;

    always @(negedge clk) begin
        cyc_n <= cyc_n + 1;
        if (select == 2'd1 && prev_sel != 2'd1) begin
            t_wait    <= cyc_n + 1;
            exp_delay <= BASE + int'(ref_prev[10:0]);
        end
        if (led_go && !prev_go)
            t_go <= cyc_n + 1;
        if (select == 2'd3 && prev_sel != 2'd3) begin
            t_result          <= cyc_n + 1;
            num_before_result <= int'(prev_num);
        end
        prev_sel <= select;
        prev_go  <= led_go;
        prev_num <= number;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_sel(input string tag, input int v, input int budget);
        int n = 0;
        while (int'(select) != v && n < budget) begin
            step(1);
            n++;
        end
        check(tag, int'(select), v);
    endtask

    task automatic press(input bit s, input bit r);
        if (s) btn_start = 1'b1;
        if (r) btn_react = 1'b1;
        step(6);
        btn_start = 1'b0;
        btn_react = 1'b0;
    endtask

    // Arm a game from IDLE and check the arm delay against the reference LFSR.
    task automatic arm_game(input logic [1:0] sw);
        sw_mode = sw;
        step(2);
        check("mode_idle", int'(mode), exp_mode(sw));
        press(1'b1, 1'b0);
        wait_sel("to_wait", 1, 20);
        sw_mode = ~sw;
        step(1);
        check("mode_frozen", int'(mode), exp_mode(sw));
        wait_sel("to_go", 2, 2050 * T + 10);
        check("go_delay", t_go - t_wait, exp_delay * T);
    endtask

    // React now: score is the number of whole ms elapsed before the react edge.
    task automatic react_now(input string tag);
        int b;
        int exp_score;
        b = cyc_n;
        exp_score = (b + 3 - t_go) / T;
        press(1'b0, 1'b1);
        wait_sel("to_result", 3, 20);
        check("react_latency", t_result - b, 4);
        check(tag, int'(number), exp_score);
        $display("game: mode %0d delay %0d ms score %0d", mode, exp_delay, number);
    endtask

    task automatic back_to_idle();
        press(1'b1, 1'b0);
        wait_sel("to_idle", 0, 20);
        check("idle_number", int'(number), 0);
    endtask

    initial begin
        int g0;
        int spur;
        logic [1:0] sw;

        step(3);
        check("rst_select", int'(select), 0);
        check("rst_number", int'(number), 0);
        check("rst_mode", int'(mode), 0);
        check("rst_led_go", int'(led_go), 0);
        rst = 1'b1;

        sw_mode = 2'b10;
        step(1);
        check("mode_hard", int'(mode), 2);
        check("idle_select", int'(select), 0);
        sw_mode = 2'b11;
        step(1);
        check("mode_coerce", int'(mode), 1);
        for (int i = 0; i < 4; i++) begin
            sw = 2'($urandom_range(0, 3));
            sw_mode = sw;
            step(1);
            check("mode_follow", int'(mode), exp_mode(sw));
        end

        // Regular game, react pressed on the tick edge of ms 37.
        arm_game(2'b01);
        step(148);
        react_now("score_37");
        press(1'b0, 1'b1);
        check("react_in_result", int'(number), 37);
        check("result_hold", int'(select), 3);
        back_to_idle();

        for (int g = 0; g < 2; g++) begin
            sw = 2'($urandom_range(0, 3));
            if (sw == 2'b10) sw = 2'b00;
            arm_game(sw);
            step($urandom_range(0, 200));
            react_now("score_rand");
            back_to_idle();
        end

        // False start: react shortly after arming.
        g0 = t_go;
        sw_mode = 2'b01;
        step(2);
        press(1'b1, 1'b0);
        wait_sel("fs_wait", 1, 20);
        step($urandom_range(0, 3));
        press(1'b0, 1'b1);
        wait_sel("fs_result", 3, 20);
        check("fs_number", int'(number), 9999);
        step(10);
        check("fs_no_go", t_go, g0);
        $display("game: false start score %0d", number);
        back_to_idle();

        // Hard mode miss.
        arm_game(2'b10);
        wait_sel("miss_result", 3, 500 * T + 20);
        check("miss_time", t_result - t_go, 500 * T + 1);
        check("miss_peak", num_before_result, 500);
        check("miss_number", int'(number), 9999);
        $display("game: hard miss score %0d", number);
        back_to_idle();

        // Simultaneous start and react in IDLE, start ignored in GO, both in RESULT.
        sw_mode = 2'b01;
        step(2);
        g0 = cyc_n;
        press(1'b1, 1'b1);
        check("sim_idle_latency", t_wait - g0, 4);
        check("sim_idle_state", int'(select), 1);
        wait_sel("sim_go", 2, 2050 * T + 10);
        check("go_delay", t_go - t_wait, exp_delay * T);
        press(1'b1, 1'b0);
        step(2);
        check("start_in_go", int'(select), 2);
        step($urandom_range(0, 40));
        react_now("score_sim");
        press(1'b1, 1'b1);
        wait_sel("sim_result_idle", 0, 20);
        check("sim_result_number", int'(number), 0);

        // Reset mid-GO with react held.
        arm_game(2'b01);
        step(10);
        btn_react = 1'b1;
        rst = 1'b0;
        #1;
        check("arst_select", int'(select), 0);
        check("arst_number", int'(number), 0);
        check("arst_led_go", int'(led_go), 0);
        check("arst_mode", int'(mode), 0);
        step(3);
        rst = 1'b1;
        spur = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (dut.react_p) spur++;
        end
        check("held_react_pulses", spur, 0);
        sw_mode = 2'b01;
        step(2);
        press(1'b1, 1'b0);
        wait_sel("held_wait", 1, 20);
        wait_sel("held_go", 2, 2050 * T + 10);
        check("go_delay", t_go - t_wait, exp_delay * T);
        btn_react = 1'b0;
        step(4);
        react_now("score_after_rst");
        back_to_idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #950000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks made", n_checks);
        $fatal(1);
    end

endmodule
